// File: rtl/ibuff_align.sv
// ibuff_align: instruction buffer and aligner in front of predecode.
// Fetch words are queued as 16-bit halfwords in a circular FIFO, and one
// aligned instruction window is presented each cycle. The window is either
// {H1,H0} for a 32-bit instruction or {16'h0,H0} for a compressed one, so
// instructions that straddle fetch-word boundaries come out whole.
module ibuff_align #(
    parameter int XLEN     = 32,
    parameter int DEPTH_HW = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            fetch_valid,
    input  logic [XLEN-1:0] fetch_data,
    input  logic [XLEN-1:0] fetch_pc,
    output logic            fetch_ready,
    input  logic            flush,
    input  logic [XLEN-1:0] flush_pc,
    output logic [XLEN-1:0] IBuff_out,
    output logic [XLEN-1:0] out_pc,
    output logic            out_valid,
    input  logic            dec_ready
);

    localparam int PW = $clog2(DEPTH_HW);
    localparam int CW = PW + 1;
    // Highest occupancy that still leaves room for a full two-halfword push.
    localparam logic [CW-1:0] READY_MAX = CW'(DEPTH_HW - 2);

    logic [15:0]     mem [DEPTH_HW];
    logic [PW-1:0]   rd_ptr;
    logic [PW-1:0]   wr_ptr;
    logic [CW-1:0]   count;
    logic [XLEN-1:0] pc_q;

    logic [15:0]     h0;
    logic [15:0]     h1;
    logic            is32;
    logic            push;
    logic            pop;
    logic [CW-1:0]   push_amt;
    logic [CW-1:0]   pop_amt;
    logic [PW-1:0]   push_ptr_amt;
    logic [PW-1:0]   pop_ptr_amt;
    logic [XLEN-1:0] pc_step;

    // Only fetch_pc[1] selects the enqueue pattern; the rest of the PC is
    // tracked internally via out_pc, and flush_pc[0] is forced to zero.
    logic unused_pc_bits;
    assign unused_pc_bits = ^{fetch_pc[XLEN-1:2], fetch_pc[0], flush_pc[0]};

    // Head decode, handshakes and the output window, all from registered state.
    always_comb begin
        h0           = mem[rd_ptr];
        h1           = mem[rd_ptr + PW'(1)];
        is32         = (h0[1:0] == 2'b11);
        out_valid    = 1'b0;
        IBuff_out    = '0;
        fetch_ready  = (count <= READY_MAX);
        push_amt     = '0;
        pop_amt      = '0;
        push_ptr_amt = '0;
        pop_ptr_amt  = '0;
        pc_step      = '0;

        if (count >= CW'(2)) begin
            out_valid = 1'b1;
        end else if (count == CW'(1)) begin
            out_valid = !is32;
        end

        if (out_valid) begin
            if (is32) begin
                IBuff_out = {h1, h0};
            end else begin
                IBuff_out = {16'h0000, h0};
            end
        end

        push = fetch_valid && fetch_ready && !flush;
        pop  = out_valid && dec_ready && !flush;

        if (push) begin
            push_amt     = fetch_pc[1] ? CW'(1) : CW'(2);
            push_ptr_amt = fetch_pc[1] ? PW'(1) : PW'(2);
        end

        if (pop) begin
            pop_amt     = is32 ? CW'(2) : CW'(1);
            pop_ptr_amt = is32 ? PW'(2) : PW'(1);
            pc_step     = is32 ? XLEN'(4) : XLEN'(2);
        end
    end

    assign out_pc = pc_q;

    // Halfword storage; contents are never reset because out_valid masks them.
    always_ff @(posedge clk) begin
        if (push) begin
            if (fetch_pc[1]) begin
                mem[wr_ptr] <= fetch_data[31:16];
            end else begin
                mem[wr_ptr]          <= fetch_data[15:0];
                mem[wr_ptr + PW'(1)] <= fetch_data[31:16];
            end
        end
    end

    // Pointer, occupancy and PC tracking; reset beats flush, flush beats push/pop.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            pc_q   <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            pc_q   <= {flush_pc[XLEN-1:1], 1'b0};
        end else begin
            wr_ptr <= wr_ptr + push_ptr_amt;
            rd_ptr <= rd_ptr + pop_ptr_amt;
            count  <= count + push_amt - pop_amt;
            pc_q   <= pc_q + pc_step;
        end
    end

endmodule

// File: tb/tb_ibuff_align.sv
// tb_ibuff_align: directed self-checking bench for ibuff_align.
// Inputs change 1 time unit after each rising edge and outputs are sampled
// at the same point, so every check sees state settled by the previous edge.
module tb_ibuff_align;

    logic        clk = 1'b0;
    logic        rst;
    logic        fetch_valid;
    logic [31:0] fetch_data;
    logic [31:0] fetch_pc;
    logic        fetch_ready;
    logic        flush;
    logic [31:0] flush_pc;
    logic [31:0] IBuff_out;
    logic [31:0] out_pc;
    logic        out_valid;
    logic        dec_ready;

    int vectors     = 0;
    int miscompares = 0;

    // Stream-test reference state: halfword source list and a halfword queue model.
    logic [15:0] hw_s[$];
    logic [15:0] mq[$];
    logic [31:0] mpc;
    logic [31:0] m_out;
    logic [31:0] s_data;
    logic        m_valid;
    logic        m_is32;
    logic        m_ready;
    logic        s_fv;
    logic        s_dr;
    int          nwords;
    int          w;
    int          cyc;

    ibuff_align #(.XLEN(32), .DEPTH_HW(8)) dut (
        .clk         (clk),
        .rst         (rst),
        .fetch_valid (fetch_valid),
        .fetch_data  (fetch_data),
        .fetch_pc    (fetch_pc),
        .fetch_ready (fetch_ready),
        .flush       (flush),
        .flush_pc    (flush_pc),
        .IBuff_out   (IBuff_out),
        .out_pc      (out_pc),
        .out_valid   (out_valid),
        .dec_ready   (dec_ready)
    );

    always #5 clk = ~clk;

    task automatic applyStimulus(input logic fv, input logic [31:0] fd, input logic [31:0] fpc,
                                 input logic fl, input logic [31:0] flpc, input logic dr);
        fetch_valid = fv;
        fetch_data  = fd;
        fetch_pc    = fpc;
        flush       = fl;
        flush_pc    = flpc;
        dec_ready   = dr;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic ev, input logic [31:0] eo,
                               input logic [31:0] ep, input logic er);
        vectors++;
        assert (out_valid === ev) else begin
            miscompares++;
            $error("[TB] FAIL %s out_valid: got %0b expected %0b", tag, out_valid, ev);
        end
        vectors++;
        assert (IBuff_out === eo) else begin
            miscompares++;
            $error("[TB] FAIL %s IBuff_out: got %h expected %h", tag, IBuff_out, eo);
        end
        vectors++;
        assert (out_pc === ep) else begin
            miscompares++;
            $error("[TB] FAIL %s out_pc: got %h expected %h", tag, out_pc, ep);
        end
        vectors++;
        assert (fetch_ready === er) else begin
            miscompares++;
            $error("[TB] FAIL %s fetch_ready: got %0b expected %0b", tag, fetch_ready, er);
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired before the bench completed");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        // Reset
        rst = 1'b1;
        applyStimulus(0, 32'h0, 32'h0, 0, 32'h0, 0);
        tick();
        tick();
        rst = 1'b0;
        checkOutput("reset", 0, 32'h0, 32'h0, 1);

        // Single 32-bit instruction, then pop
        applyStimulus(1, 32'h00A00093, 32'h0, 0, 32'h0, 0);
        tick();
        applyStimulus(0, 32'h0, 32'h0, 0, 32'h0, 0);
        checkOutput("single32", 1, 32'h00A00093, 32'h0, 1);
        applyStimulus(0, 32'h0, 32'h0, 0, 32'h0, 1);
        tick();
        applyStimulus(0, 32'h0, 32'h0, 0, 32'h0, 0);
        checkOutput("single32_pop", 0, 32'h0, 32'h4, 1);

        // Compressed then a 32-bit instruction straddling two fetch words
        applyStimulus(0, 32'h0, 32'h0, 1, 32'h100, 0);
        tick();
        checkOutput("flush100", 0, 32'h0, 32'h100, 1);
        applyStimulus(1, 32'h00934505, 32'h100, 0, 32'h0, 0);
        tick();
        applyStimulus(1, 32'h12340093, 32'h104, 0, 32'h0, 0);
        tick();
        applyStimulus(0, 32'h0, 32'h0, 0, 32'h0, 0);
        checkOutput("cli", 1, 32'h00004505, 32'h100, 1);
        applyStimulus(0, 32'h0, 32'h0, 0, 32'h0, 1);
        tick();
        checkOutput("straddle", 1, 32'h00930093, 32'h102, 1);
        tick();
        checkOutput("tail_c", 1, 32'h00001234, 32'h106, 1);
        tick();
        applyStimulus(0, 32'h0, 32'h0, 0, 32'h0, 0);
        checkOutput("drained", 0, 32'h0, 32'h108, 1);

        // Halfword-aligned branch target
        applyStimulus(0, 32'h0, 32'h0, 1, 32'h202, 0);
        tick();
        checkOutput("flush202", 0, 32'h0, 32'h202, 1);
        applyStimulus(1, 32'h4501ABCD, 32'h202, 0, 32'h0, 0);
        tick();
        applyStimulus(0, 32'h0, 32'h0, 0, 32'h0, 0);
        checkOutput("hw_target", 1, 32'h00004501, 32'h202, 1);
        applyStimulus(0, 32'h0, 32'h0, 0, 32'h0, 1);
        tick();
        applyStimulus(0, 32'h0, 32'h0, 0, 32'h0, 0);
        checkOutput("hw_target_pop", 0, 32'h0, 32'h204, 1);

        // Fill to full with decode stalled, then drain
        applyStimulus(0, 32'h0, 32'h0, 1, 32'h300, 0);
        tick();
        applyStimulus(1, 32'h11110013, 32'h300, 0, 32'h0, 0);
        tick();
        checkOutput("fill1", 1, 32'h11110013, 32'h300, 1);
        applyStimulus(1, 32'h22220093, 32'h304, 0, 32'h0, 0);
        tick();
        applyStimulus(1, 32'h33330113, 32'h308, 0, 32'h0, 0);
        tick();
        checkOutput("fill3", 1, 32'h11110013, 32'h300, 1);
        applyStimulus(1, 32'h44440193, 32'h30C, 0, 32'h0, 0);
        tick();
        checkOutput("full", 1, 32'h11110013, 32'h300, 0);
        applyStimulus(1, 32'h55550213, 32'h310, 0, 32'h0, 0);
        tick();
        checkOutput("full_reject", 1, 32'h11110013, 32'h300, 0);
        applyStimulus(0, 32'h0, 32'h0, 0, 32'h0, 1);
        tick();
        checkOutput("drain1", 1, 32'h22220093, 32'h304, 1);
        tick();
        checkOutput("drain2", 1, 32'h33330113, 32'h308, 1);
        tick();
        checkOutput("drain3", 1, 32'h44440193, 32'h30C, 1);
        tick();
        checkOutput("drain4", 0, 32'h0, 32'h310, 1);

        // Flush colliding with push and pop at count 3
        applyStimulus(0, 32'h0, 32'h0, 1, 32'h500, 0);
        tick();
        applyStimulus(1, 32'h45014505, 32'h500, 0, 32'h0, 0);
        tick();
        applyStimulus(1, 32'h45090000, 32'h506, 0, 32'h0, 0);
        tick();
        checkOutput("cnt3", 1, 32'h00004505, 32'h500, 1);
        applyStimulus(1, 32'h12345678, 32'h508, 1, 32'h603, 1);
        tick();
        applyStimulus(0, 32'h0, 32'h0, 0, 32'h0, 0);
        checkOutput("flush_collide", 0, 32'h0, 32'h602, 1);
        applyStimulus(1, 32'h45110000, 32'h602, 0, 32'h0, 0);
        tick();
        applyStimulus(0, 32'h0, 32'h0, 0, 32'h0, 0);
        checkOutput("after_flush", 1, 32'h00004511, 32'h602, 1);

        // Continuous mixed stream with bubbles and stalls, wrapping several times
        for (int k = 0; k < 20; k++) begin
            if (k % 3 != 1) begin
                hw_s.push_back({8'(k), 8'h13});
                hw_s.push_back(16'hA000 | 16'(k));
            end else begin
                hw_s.push_back({8'(k), 8'h01});
            end
        end
        if (hw_s.size() % 2 != 0) hw_s.push_back(16'h0001);
        nwords = hw_s.size() / 2;

        applyStimulus(0, 32'h0, 32'h0, 1, 32'h400, 0);
        tick();
        mpc = 32'h400;
        w   = 0;
        cyc = 0;
        while ((w < nwords || mq.size() != 0) && cyc < 300) begin
            m_is32  = 1'b0;
            m_valid = 1'b0;
            m_out   = 32'h0;
            if (mq.size() > 0) begin
                m_is32  = (mq[0][1:0] == 2'b11);
                m_valid = !m_is32 || (mq.size() >= 2);
                if (m_valid) begin
                    if (m_is32) m_out = {mq[1], mq[0]};
                    else        m_out = {16'h0000, mq[0]};
                end
            end
            m_ready = ((8 - int'(mq.size())) >= 2);
            checkOutput("stream", m_valid, m_out, mpc, m_ready);

            s_fv   = (w < nwords) && (cyc % 7 != 5);
            s_dr   = (cyc % 4 != 3);
            s_data = 32'h0;
            if (s_fv) s_data = {hw_s[2*w+1], hw_s[2*w]};
            applyStimulus(s_fv, s_data, 32'h400 + 32'(4*w), 0, 32'h0, s_dr);
            tick();

            if (m_valid && s_dr) begin
                void'(mq.pop_front());
                if (m_is32) void'(mq.pop_front());
                mpc = mpc + (m_is32 ? 32'd4 : 32'd2);
            end
            if (s_fv && m_ready) begin
                mq.push_back(hw_s[2*w]);
                mq.push_back(hw_s[2*w+1]);
                w++;
            end
            cyc++;
        end
        vectors++;
        assert (cyc < 300) else begin
            miscompares++;
            $error("[TB] FAIL stream_timeout: cycles %0d limit %0d", cyc, 300);
        end
        applyStimulus(0, 32'h0, 32'h0, 0, 32'h0, 0);
        checkOutput("stream_end", 0, 32'h0, mpc, 1);

        // Reset mid-stream takes priority over flush, push and pop
        applyStimulus(1, 32'h00A00093, 32'h800, 0, 32'h0, 0);
        tick();
        checkOutput("pre_reset", 1, 32'h00A00093, mpc, 1);
        rst = 1'b1;
        applyStimulus(1, 32'h00B00113, 32'h804, 1, 32'h777, 1);
        tick();
        rst = 1'b0;
        applyStimulus(0, 32'h0, 32'h0, 0, 32'h0, 0);
        checkOutput("mid_reset", 0, 32'h0, 32'h0, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/ibuff_align.md
# ibuff_align

Instruction buffer and aligner sitting directly upstream of predecode. It accepts 32-bit fetch words from the I-cache/fetch stage and queues them as 16-bit halfwords in a circular FIFO. Each cycle it presents one 32-bit-aligned instruction window and its PC to predecode, and it correctly straddles 16-bit compressed and 32-bit instructions across fetch-word boundaries. It also absorbs redirect flushes, including halfword-aligned branch targets.

## Interface
- XLEN, 32, instruction/PC width; only 32 is supported.
- DEPTH_HW, 8, FIFO depth in halfwords; must be a power of 2 and ≥ 4.

- clk  input  1  sole clock; all state updates on posedge.
- rst  input  1  synchronous, active-high reset.
- fetch_valid  input  1  fetch_data/fetch_pc valid this cycle.
- fetch_data  input  32  fetch word; [15:0] is the halfword at PC&~3, [31:16] is the halfword at (PC&~3)+2.
- fetch_pc  input  32  PC of the first useful halfword; bit 1 set means only [31:16] is enqueued.
- fetch_ready  output  1  FIFO has ≥ 2 free halfword slots.
- flush  input  1  redirect; discard all queued halfwords.
- flush_pc  input  32  new PC (bit 0 ignored, treated as 0).
- IBuff_out  output  32  instruction window to predecode IBuff_in.
- out_pc  output  32  PC of IBuff_out[15:0].
- out_valid  output  1  IBuff_out holds a complete instruction.
- dec_ready  input  1  predecode/decode accepts IBuff_out this cycle.

## Operation
- Storage is DEPTH_HW × 16-bit entries, with rd_ptr and wr_ptr of log2(DEPTH_HW) bits that wrap modulo DEPTH_HW, and count of log2(DEPTH_HW)+1 bits.
- A push occurs when fetch_valid && fetch_ready && !flush.
  - If fetch_pc[1]=0, write [15:0] then [31:16], so count += 2.
  - If fetch_pc[1]=1, write only [31:16], so count += 1.
- Head halfword H0 = entry[rd_ptr]; H1 = entry[rd_ptr+1 mod DEPTH_HW].
- An instruction is 32-bit when H0[1:0]==2'b11; otherwise it is compressed.
- out_valid is 1 when:
  - count ≥ 2, or
  - count == 1 and H0 is compressed.
- IBuff_out:
  - For a 32-bit instruction: {H1, H0}.
  - For a compressed instruction: {16'h0000, H0}. The upper half is forced to zero even when H1 is present.
  - When out_valid=0: 32'h0.
- A pop occurs when out_valid && dec_ready && !flush.
  - rd_ptr and count advance by 2 for a 32-bit instruction, or by 1 for a compressed one.
  - out_pc advances by 4 or 2 respectively, mod 2^32.
- Simultaneous push and pop: count_next = count + pushed − popped. Both are applied in the same cycle.
- fetch_ready = (DEPTH_HW − count) ≥ 2. It is computed from registered count only; a same-cycle pop does not raise it.
- Flush:
  - rd_ptr, wr_ptr and count are cleared to 0, and out_pc ← {flush_pc[31:1],1'b0}.
  - Any push or pop in the same cycle is dropped.
  - The first fetch after a flush is expected to carry fetch_pc == flush_pc; the block does not check this.
- Reset:
  - Pointers, count and out_pc are 0, so out_valid=0, IBuff_out=32'h0 and fetch_ready=1.
  - FIFO contents are don't-care and must never be visible, because out_valid masks them.
  - rst has priority over flush, push and pop.

## Timing
- A push in cycle N is visible on IBuff_out/out_valid in cycle N+1. There is no bypass from fetch_data to IBuff_out.
- Outputs are combinational from registered state (pointers, count, entries, out_pc) only.
- A pop in cycle N presents the next instruction in cycle N+1. Sustained throughput is one instruction per cycle while data is available.
- Flush asserted in cycle N gives out_valid=0 in N+1, and out_pc=flush_pc in N+1.
- Pointer wrap from DEPTH_HW−1 to 0, including a 32-bit instruction whose H0 is at DEPTH_HW−1 and H1 at 0, must be seamless.

## Test plan
- Reset, then push 0x00A00093 at fetch_pc 0x0. Cycle+1 shows out_valid=1, IBuff_out=0x00A00093 and out_pc=0x0. A pop with dec_ready=1 gives out_pc=0x4 and out_valid=0.
- Push 0x00934505 at pc 0x100 (c.li at 0x100, low half of a 32-bit instruction at 0x102), then 0x1234_0093.
  - The first output is IBuff_out=0x00004505, out_pc=0x100.
  - The next output is 0x00930093 at out_pc=0x102, straddling both fetch words.
- Flush with flush_pc=0x202, then push 0xABCD4501 with fetch_pc=0x202. Only 0xABCD is enqueued, count=1, and it is compressed, so IBuff_out=0x0000ABCD... Use 0x4501ABCD instead: this gives IBuff_out=0x00004501 and out_pc=0x202.
- Hold dec_ready=0 and push four 32-bit words with DEPTH_HW=8. fetch_ready drops to 0 after the fourth push, and a fifth fetch_valid is not accepted. Then set dec_ready=1: fetch_ready returns to 1 once count ≤ 6.
- Run a continuous stream with interleaved compressed and 32-bit instructions for more than 3× DEPTH_HW halfwords. Check wrap correctness, and that out_pc matches a reference PC model each cycle.
- Assert flush in the same cycle as push and pop with count=3. Next cycle count=0, out_valid=0 and out_pc=flush_pc. Assert rst mid-stream: next cycle all outputs are at reset values.
